pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side program-counter stage of the single-cycle MIPS core, directly upstream of the datapath top. Holds the architectural PC, presents it with a valid flag to the instruction path, and computes the next PC from sequential increment, conditional branch (beq/bne), or jump (j). Supports stall via a ready handshake and a halt/resume state machine, and keeps retired-instruction and cycle counters for debug.

## Interface

- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- CNT_W, 32, width of the retired and cycle counters
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk upstream
- ready  in  1  datapath accepts the presented PC this cycle
- instruction  in  32  instruction word fetched at the current pc
- zero  in  1  ALU zero flag for the current instruction
- halt_req  in  1  stop fetching after the current instruction retires
- resume  in  1  one-cycle pulse; leave HALT
- pc  out  32  current PC to the instruction path
- pc_valid  out  1  pc is a live fetch address
- halted  out  1  sequencer is in HALT
- retired_cnt  out  CNT_W  instructions accepted (pc_valid & ready)
- cycle_cnt  out  CNT_W  cycles spent in RUN

## Operation

- States: RESET_WAIT, RUN, HALT. Encoding in package.
- RESET_WAIT: entered asynchronously on rst_n low; pc=RESET_VECTOR, pc_valid=0, halted=0, counters=0. Leaves to RUN on first clk edge with rst_n high.
- RUN: pc_valid=1. cycle_cnt increments every RUN cycle (wraps at 2^CNT_W). If ready=0: pc and retired_cnt hold; branch/jump/halt_req ignored that cycle (datapath re-presents them).
- RUN with ready=1: retired_cnt+1; pc <= next_pc; if halt_req=1 go HALT (next_pc still committed).
- next_pc selection, opcode = instruction[31:26], pc4 = pc+4 (mod 2^32):
  - j (6'h02): {pc4[31:28], instruction[25:0], 2'b00}
  - beq (6'h04) and zero=1, or bne (6'h05) and zero=0: pc4 + (sign_ext(instruction[15:0]) << 2)
  - otherwise: pc4
- Branch offset sign-extended (unlike the datapath immediate path, which zero-extends). All arithmetic mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- HALT: pc_valid=0, halted=1, pc and retired_cnt hold, cycle_cnt holds. resume=1 -> RUN next edge. halt_req ignored in HALT. resume ignored outside HALT.
- rst_n low in any state, mid-stall or mid-halt: immediate return to RESET_WAIT values.

## Timing

- Reset values: pc=RESET_VECTOR, pc_valid=0, halted=0, retired_cnt=0, cycle_cnt=0.
- pc_valid rises one edge after rst_n release; first fetch address RESET_VECTOR.
- Redirect latency: one cycle; branch/jump target appears on pc the edge after the accepting cycle. No delay slot, no flush needed.
- instruction and zero sampled only in cycles where pc_valid & ready.
- halted rises the edge after the accepting cycle with halt_req=1; pc then shows the already-computed next_pc, frozen.
- resume to pc_valid=1: one edge.
- All outputs registered; no combinational path from inputs to pc/pc_valid/halted.

## Structure

- Shared package mips_fetch_pkg: state enum, opcode constants OP_J, OP_BEQ, OP_BNE, default RESET_VECTOR; reused by the control unit.
- One sub-module: pc_next_calc (combinational; pc, instruction, zero -> next_pc). Sequencer instantiates it and owns FSM, PC register, counters.

## Test plan

- Reset then 3 cycles ready=1, NOPs -> pc 0,4,8,C; retired_cnt=3; pc_valid=0 during reset.
- pc=0x10, beq offset 0xFFFE, zero=1 -> next pc=0x0C; same with zero=0 -> 0x14; bne with zero=0, offset 3 -> 0x20.
- pc=0xF000_0000, j target 26'h0000100 -> next pc=0xF000_0400.
- ready=0 for 2 cycles with j presented -> pc holds, retired_cnt unchanged, cycle_cnt +2; ready=1 -> jump taken.
- halt_req with ready=1 at pc=0x8 -> halted=1, pc=0xC frozen, pc_valid=0 for 5 cycles; resume pulse -> pc_valid=1, pc=0xC.
- rst_n low mid-HALT and mid-stall -> immediate pc=RESET_VECTOR, counters 0; pc=0xFFFF_FFFC NOP -> pc wraps to 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side definitions: sequencer state encoding, opcodes, reset vector.
package mips_fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 6;
    localparam int unsigned IMM_W = 16;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALT       = 2'd2
    } fetch_state_e;

    localparam logic [OPC_W-1:0] OP_J   = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE = 6'h05;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Branch displacement in bytes: sign-extended word offset.
    function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, taken beq/bne, or j.
module pc_next_calc
    import mips_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instruction_i,
    input  logic            zero_i,
    output logic [XLEN-1:0] next_pc_c_o
);

    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  jump_tgt;
    logic [XLEN-1:0]  branch_tgt;
    logic [OPC_W-1:0] opcode;
    logic             branch_taken;

    always_comb begin
        opcode       = instruction_i[31:26];
        pc4          = pc_i + XLEN'(4);
        jump_tgt     = {pc4[31:28], instruction_i[25:0], 2'b00};
        branch_tgt   = pc4 + branch_offset(instruction_i[IMM_W-1:0]);
        branch_taken = ((opcode == OP_BEQ) && zero_i) ||
                       ((opcode == OP_BNE) && !zero_i);

        next_pc_c_o = pc4;
        if (opcode == OP_J) begin
            next_pc_c_o = jump_tgt;
        end else if (branch_taken) begin
            next_pc_c_o = branch_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC stage: PC register, run/halt FSM, retired and run-cycle counters.
module pc_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready,
    input  logic [XLEN-1:0]  instruction,
    input  logic             zero,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    fetch_state_e     state_q,  state_d;
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic             valid_q,  valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] ret_q,    ret_d;
    logic [CNT_W-1:0] cyc_q,    cyc_d;
    logic [XLEN-1:0]  next_pc;

    pc_next_calc u_pc_next_calc (
        .pc_i          (pc_q),
        .instruction_i (instruction),
        .zero_i        (zero),
        .next_pc_c_o   (next_pc)
    );

    // State register and all architectural outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RESET_WAIT;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ret_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            ret_q    <= ret_d;
            cyc_q    <= cyc_d;
        end
    end

    // Next state; a stalled RUN cycle ignores redirect and halt_req entirely.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            ST_RESET_WAIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (ready) begin
                    ret_d = ret_q + CNT_W'(1);
                    pc_d  = next_pc;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RESET_WAIT;
            end
        endcase

        valid_d  = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign halted      = halted_q;
    assign retired_cnt = ret_q;
    assign cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, corner sequences, random vs. model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [31:0] instruction;
    logic        zero;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic [31:0] retired_cnt;
    logic [31:0] cycle_cnt;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .instruction (instruction),
        .zero        (zero),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Reference model: 0 = waiting after reset, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_cyc;

    typedef struct {
        logic        r;
        logic [31:0] ins;
        logic        z;
        logic        h;
        logic        res;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halted;
        logic [31:0] e_ret;
        logic [31:0] e_cyc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_halted, input logic [31:0] e_ret, input logic [31:0] e_cyc);
        chk({tag, ".pc"},          pc,                  e_pc);
        chk({tag, ".pc_valid"},    {31'b0, pc_valid},   {31'b0, e_valid});
        chk({tag, ".halted"},      {31'b0, halted},     {31'b0, e_halted});
        chk({tag, ".retired_cnt"}, retired_cnt,         e_ret);
        chk({tag, ".cycle_cnt"},   cycle_cnt,           e_cyc);
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins, input logic z);
        logic [31:0] pc4;
        logic [5:0]  op;
        int          off;
        pc4 = cur + 32'd4;
        op  = ins[31:26];
        if (op == 6'h02) return (pc4 & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        if ((op == 6'h04 && z) || (op == 6'h05 && !z)) begin
            off = $signed(ins[15:0]);
            return pc4 + 32'(off * 4);
        end
        return pc4;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_cyc  = 32'h0;
    endtask

    task automatic model_edge(input logic r, input logic [31:0] ins, input logic z,
                              input logic h, input logic res);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_cyc = m_cyc + 1;
            if (r) begin
                m_ret = m_ret + 1;
                m_pc  = ref_next(m_pc, ins, z);
                if (h) m_mode = 2;
            end
        end else if (res) begin
            m_mode = 1;
        end
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_pc, m_mode == 1, m_mode == 2, m_ret, m_cyc);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic z,
                         input logic h, input logic res);
        ready = r; instruction = ins; zero = z; halt_req = h; resume = res;
    endtask

    task automatic step(input logic r, input logic [31:0] ins, input logic z,
                        input logic h, input logic res, input string tag);
        drive(r, ins, z, h, res);
        @(posedge clk);
        #1;
        model_edge(r, ins, z, h, res);
        check_model(tag);
    endtask

    // Called at least 1 time unit after an edge; checks the asynchronous entry too.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model({tag, ".async"});
        chk({tag, ".pc_const"}, pc, 32'h0);
        @(posedge clk);
        #1;
        check_model({tag, ".hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cyc_at_halt;
        logic [31:0] ins;

        vecs[0]  = '{1'b1, NOP,          1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'd1,  32'd1};
        vecs[1]  = '{1'b1, NOP,          1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'd2,  32'd2};
        vecs[2]  = '{1'b1, NOP,          1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'd3,  32'd3};
        vecs[3]  = '{1'b1, 32'h8C00_0010, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd4,  32'd4};
        vecs[4]  = '{1'b1, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'd5,  32'd5};
        vecs[5]  = '{1'b1, NOP,          1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd6,  32'd6};
        vecs[6]  = '{1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 1'b1, 1'b0, 32'd7,  32'd7};
        vecs[7]  = '{1'b1, 32'h0800_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd8,  32'd8};
        vecs[8]  = '{1'b1, 32'h1400_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'd9,  32'd9};
        vecs[9]  = '{1'b1, 32'h1400_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 1'b1, 1'b0, 32'd10, 32'd10};
        vecs[10] = '{1'b0, 32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0024, 1'b1, 1'b0, 32'd10, 32'd11};
        vecs[11] = '{1'b0, 32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0024, 1'b1, 1'b0, 32'd10, 32'd12};
        vecs[12] = '{1'b1, 32'h0800_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'd11, 32'd13};
        vecs[13] = '{1'b1, 32'h1000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0408, 1'b1, 1'b0, 32'd12, 32'd14};

        // Power-up reset and directed table.
        rst_n = 1'b1;
        drive(1'b1, NOP, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all("reset_async", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset_hold", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("release", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].r, vecs[i].ins, vecs[i].z, vecs[i].h, vecs[i].res);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                      vecs[i].e_halted, vecs[i].e_ret, vecs[i].e_cyc);
        end

        // Reach the top address segment through a wrapping backward branch, then jump and wrap.
        apply_reset("wrap_rst");
        step(1'b0, NOP, 1'b0, 1'b0, 1'b0, "wrap_release");
        step(1'b1, 32'h1000_8000, 1'b1, 1'b0, 1'b0, "wrap_beq_neg");
        chk("wrap_beq_neg_const", pc, 32'hFFFE_0004);
        step(1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0, "wrap_j0");
        chk("wrap_j0_const", pc, 32'hF000_0000);
        step(1'b1, 32'h0800_0100, 1'b0, 1'b0, 1'b0, "wrap_j100");
        chk("wrap_j100_const", pc, 32'hF000_0400);
        step(1'b1, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, "wrap_jmax");
        chk("wrap_jmax_const", pc, 32'hFFFF_FFFC);
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, "wrap_nop");
        chk("wrap_to_zero", pc, 32'h0);

        // Halt at pc 0x8, stay frozen, resume, then reset mid-halt.
        apply_reset("halt_rst");
        step(1'b0, NOP, 1'b0, 1'b0, 1'b0, "halt_release");
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, "halt_run0");
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, "halt_run1");
        step(1'b1, NOP, 1'b0, 1'b1, 1'b0, "halt_enter");
        check_all("halt_enter_const", 32'h0000_000C, 1'b0, 1'b1, 32'd3, 32'd3);
        cyc_at_halt = cycle_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 32'h0800_0040, 1'b0, 1'b1, 1'b0, $sformatf("halt_frozen%0d", i));
            chk($sformatf("halt_frozen%0d.pc_const", i), pc, 32'h0000_000C);
            chk($sformatf("halt_frozen%0d.cyc_held", i), cycle_cnt, cyc_at_halt);
        end
        step(1'b0, NOP, 1'b0, 1'b0, 1'b1, "halt_resume");
        check_all("halt_resume_const", 32'h0000_000C, 1'b1, 1'b0, 32'd3, 32'd3);
        step(1'b1, NOP, 1'b0, 1'b1, 1'b0, "halt_again");
        apply_reset("midhalt_rst");

        // Reset in the middle of a stall.
        step(1'b0, NOP, 1'b0, 1'b0, 1'b0, "stall_release");
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, "stall_run");
        step(1'b0, 32'h0800_0100, 1'b0, 1'b0, 1'b0, "stall_hold");
        apply_reset("midstall_rst");

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset($sformatf("rnd_rst%0d", n));
            end else begin
                case ($urandom_range(0, 4))
                    0:       ins = {6'h00, 26'($urandom)};
                    1:       ins = {6'h02, 26'($urandom)};
                    2:       ins = {6'h04, 26'($urandom)};
                    3:       ins = {6'h05, 26'($urandom)};
                    default: ins = $urandom;
                endcase
                step($urandom_range(0, 3) != 0, ins, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                     $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
